// File: rtl/lab_pkg.sv
// Shared constants and the debounce state encoding for the pulse-generator lab.
package lab_pkg;

  localparam int CLK_HZ           = 50_000_000;
  localparam int DEBOUNCE_CYC_DEF = CLK_HZ / 1000 * 10;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce_if.sv
// Button-side bundle: raw pad level in, debounced level/strobes/mode out.
interface key_debounce_if;

  logic key_raw;
  logic key_level;
  logic press;
  logic release_strobe;
  logic mode;

  modport master (
    output key_raw,
    input  key_level,
    input  press,
    input  release_strobe,
    input  mode
  );

  modport slave (
    input  key_raw,
    output key_level,
    output press,
    output release_strobe,
    output mode
  );

endinterface

// File: rtl/key_debounce_sync2.sv
// Generic two-flop synchroniser for asynchronous pad inputs; both flops reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg <= {2{RST_VAL}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, stable-time filter, press/release strobes and a
// mode bit that toggles on each accepted press.
module key_debounce
  import lab_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter logic MODE_RST     = 1'b1
) (
  input  logic    sys_clk,
  input  logic    rst_n,
  key_debounce_if.slave bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       key_sync;
  logic       key_s;

  key_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic       key_level_reg, key_level_next;
  logic       press_reg, press_next;
  logic       release_reg, release_next;
  logic       mode_reg, mode_next;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (bus.key_raw),
    .q     (key_sync)
  );

  // Pad is active-low; internally 1 means pressed.
  assign key_s = ~key_sync;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    mode_next    = mode_reg;

    case (state_reg)
      UP: begin
        if (key_s) begin
          state_next = FILT_DN;
          cnt_next   = CNT_ONE;
        end
      end
      FILT_DN: begin
        // A mismatching sample wins even on the final filter cycle.
        if (!key_s) begin
          state_next = UP;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DOWN;
          cnt_next   = '0;
          press_next = 1'b1;
          mode_next  = ~mode_reg;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DOWN: begin
        if (!key_s) begin
          state_next = FILT_UP;
          cnt_next   = CNT_ONE;
        end
      end
      FILT_UP: begin
        if (key_s) begin
          state_next = DOWN;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = UP;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = UP;
        cnt_next   = '0;
      end
    endcase

    key_level_next = (state_next == DOWN) || (state_next == FILT_UP);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg     <= UP;
      cnt_reg       <= '0;
      key_level_reg <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      mode_reg      <= MODE_RST;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      key_level_reg <= key_level_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      mode_reg      <= mode_next;
    end
  end

  assign bus.key_level      = key_level_reg;
  assign bus.press          = press_reg;
  assign bus.release_strobe = release_reg;
  assign bus.mode           = mode_reg;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a stable-run reference model predicts every cycle's
// outputs; a negedge monitor pops and compares.
module tb_key_debounce;

  localparam int   DEB      = 8;
  localparam logic MODE_RST = 1'b1;

  typedef struct packed {
    int   cyc;
    logic level;
    logic press;
    logic rel;
    logic mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  key_debounce_if bus ();

  key_debounce #(
    .DEBOUNCE_CYC (DEB),
    .MODE_RST     (MODE_RST)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  int   last_press_cyc = -1;
  int   last_rel_cyc   = -1;
  int   press_seen     = 0;
  int   rel_seen       = 0;

  // Reference model: the pressed level seen by the filter is the raw pad value two
  // edges old, inverted; a change is accepted after DEB consecutive disagreeing samples.
  bit   m_level;
  bit   m_mode;
  int   m_run;
  bit   m_h1, m_h2;

  task automatic model_edge(input bit r, input bit rn, output exp_t e);
    bit ks;
    e.press = 1'b0;
    e.rel   = 1'b0;
    if (!rn) begin
      m_level = 1'b0;
      m_mode  = MODE_RST;
      m_run   = 0;
      m_h1    = 1'b1;
      m_h2    = 1'b1;
    end else begin
      ks   = ~m_h2;
      m_h2 = m_h1;
      m_h1 = r;
      if (ks != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = ks;
          m_run   = 0;
          if (ks) begin
            e.press = 1'b1;
            m_mode  = ~m_mode;
          end else begin
            e.rel = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    e.level = m_level;
    e.mode  = m_mode;
    e.cyc   = cyc;
  endtask

  task automatic step(input bit r, input bit rn);
    exp_t e;
    bus.key_raw = r;
    rst_n       = rn;
    @(posedge clk);
    cyc++;
    model_edge(r, rn, e);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: one comparison per clock, one printed line per strobe transaction.
  initial begin
    exp_t e;
    logic [3:0] act, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e    = exp_q.pop_front();
        act  = {bus.key_level, bus.press, bus.release_strobe, bus.mode};
        want = {e.level, e.press, e.rel, e.mode};
        checks++;
        if (act !== want) begin
          failures++;
          $display("FAIL outputs cyc=%0d level/press/release/mode got=%b want=%b",
                   e.cyc, act, want);
        end else if (want[2] || want[1]) begin
          $display("TXN cyc=%0d press=%0b release=%0b level=%0b mode=%0b",
                   e.cyc, want[2], want[1], want[3], want[0]);
        end
        if (bus.press === 1'b1) begin
          last_press_cyc = e.cyc;
          press_seen++;
        end
        if (bus.release_strobe === 1'b1) begin
          last_rel_cyc = e.cyc;
          rel_seen++;
        end
      end
    end
  end

  initial begin
    int t0;
    int p0;
    int len;
    bit v;

    bus.key_raw = 1'b1;
    rst_n       = 1'b0;

    // Reset, then idle released for 20 cycles.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1);

    // Clean press: strobe exactly DEB+2 cycles after the pad edge.
    t0 = cyc;
    repeat (14) step(1'b0, 1'b1);
    @(negedge clk);
    check_eq("press_latency", last_press_cyc, t0 + DEB + 2);

    // Clean release.
    t0 = cyc;
    p0 = press_seen;
    repeat (14) step(1'b1, 1'b1);
    @(negedge clk);
    check_eq("release_latency", last_rel_cyc, t0 + DEB + 2);
    check_eq("no_press_on_release", press_seen, p0);

    // Bounce: 5 low, 1 high, 7 low, then high.
    p0 = press_seen;
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b1);
    repeat (15) step(1'b1, 1'b1);
    @(negedge clk);
    check_eq("bounce_no_press", press_seen, p0);
    check_eq("bounce_level", int'(bus.key_level), 0);

    // Two full press/release cycles.
    p0 = press_seen;
    t0 = rel_seen;
    repeat (2) begin
      repeat (12) step(1'b0, 1'b1);
      repeat (12) step(1'b1, 1'b1);
    end
    @(negedge clk);
    check_eq("two_cycles_press", press_seen - p0, 2);
    check_eq("two_cycles_release", rel_seen - t0, 2);

    // Reset at FILT_DN count 5 with key still low; press re-filtered from scratch.
    repeat (7) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    t0 = cyc;
    repeat (14) step(1'b0, 1'b1);
    @(negedge clk);
    check_eq("press_after_reset", last_press_cyc, t0 + DEB + 2);
    repeat (14) step(1'b1, 1'b1);

    // Randomised segments straddling the filter length, with occasional resets.
    v = 1'b1;
    repeat (60) begin
      len = $urandom_range(1, 14);
      v   = ~v;
      if ($urandom_range(0, 19) == 0) step(v, 1'b0);
      repeat (len) step(v, 1'b1);
    end
    repeat (14) step(1'b1, 1'b1);

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Conditions one raw, active-low push-button into clean control signals for the pulse generator that follows it. It synchronises the pad input, rejects bounce with a stable-time filter and emits single-cycle press/release strobes. It also keeps a toggling mode bit that drives the generator's `key` period-select input directly.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 500_000 (10 ms at 50 MHz): number of consecutive stable synchronised samples required to accept a level change; legal range 2..2^24−1.
- `MODE_RST`, default 1'b1: reset value of `mode`. 1 selects the generator's short period.

Ports:
- `sys_clk` in 1: system clock, 50 MHz; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `key_raw` in 1: asynchronous pad input; 0 = pressed.
- `key_level` out 1: debounced level; 1 = pressed.
- `press` out 1: one-cycle strobe when a press is accepted.
- `release` out 1: one-cycle strobe when a release is accepted.
- `mode` out 1: toggles on every accepted press; wired to the generator's `key` input.

## Operation
- **Synchroniser:** two flops; both reset to 1 (released). `key_s` = second-stage output, inverted so that 1 means pressed.
- **State machine** (4 states, reset state `UP`):
  - `UP`: `key_level`=0. If `key_s`=1, go to `FILT_DN` and set `cnt` to 1.
  - `FILT_DN`: if `key_s`=0, return to `UP` and clear `cnt`. Otherwise, when `cnt`==`DEBOUNCE_CYC`−1, go to `DOWN`, assert `press` and toggle `mode`. Otherwise increment `cnt`.
  - `DOWN`: `key_level`=1. If `key_s`=0, go to `FILT_UP` and set `cnt` to 1.
  - `FILT_UP`: mirror of `FILT_DN`. On a glitch (`key_s`=1), return to `DOWN`. On count completion, go to `UP` and assert `release`.
- **Counter:** `cnt` width is clog2(`DEBOUNCE_CYC`+1). It saturates and cannot wrap, because every filter state exits at the limit.
- `key_level` is registered and reflects the state: 1 in `DOWN` and `FILT_UP`, 0 in `UP` and `FILT_DN`.
- `press` and `release` are never asserted in the same cycle, and each is never high for two consecutive cycles.
- Reset mid-filter: the FSM goes to `UP`, `cnt` goes to 0, `mode` goes to `MODE_RST`, all strobes go to 0. A button still held after reset is then filtered as a fresh press.
- Bounce shorter than `DEBOUNCE_CYC` cycles produces no output activity.

## Timing
- Reset values: `key_level`=0, `press`=0, `release`=0, `mode`=`MODE_RST`, synchroniser flops = 1, `cnt`=0.
- Latency from a clean `key_raw` edge to `press` or `release` is exactly `DEBOUNCE_CYC`+2 cycles: 2 cycles of synchroniser plus `DEBOUNCE_CYC` filter cycles.
- `key_level` changes in the same cycle that `press` or `release` is high.
- `mode` flips in the same cycle as `press`; the new value is visible to the generator on the next edge.
- A glitch on the last filter cycle (`cnt`==`DEBOUNCE_CYC`−1 with a mismatching sample) aborts acceptance; the mismatch takes priority.

## Structure
- Shared package `lab_pkg` holds:
  - `CLK_HZ` = 50_000_000.
  - The `DEBOUNCE_CYC` default, derived as `CLK_HZ`/1000*10.
  - The 2-bit state encoding (`UP`=0, `FILT_DN`=1, `DOWN`=2, `FILT_UP`=3).
- One natural sub-module, `sync2`: the generic two-flop synchroniser with a reset-value parameter. It is reused for other pad inputs.
- Everything else stays in `key_debounce`.

## Test plan
All scenarios use `DEBOUNCE_CYC`=8.
- Reset with `key_raw`=1 → `key_level`=0, `press`=`release`=0, `mode`=1, held for 20 cycles.
- Drive `key_raw`=0 from cycle 0 and hold → `press` high only in cycle 10, `key_level`=1 from cycle 10, `mode` 1→0 in cycle 10.
- Bounce: `key_raw` low for 5 cycles, high for 1, low for 7, then high → no `press`, `key_level` stays 0.
- Press held, then release clean → `release` one cycle high exactly 10 cycles after the rising edge of `key_raw`; no `press` strobe during the release.
- Two full press/release cycles → `mode` goes 1→0→1, two `press` strobes and two `release` strobes, never coincident.
- Assert `rst_n`=0 at `FILT_DN` count 5 with the key still low → outputs return to reset values. After deassertion, `press` occurs 10 cycles later (the key is re-filtered from scratch).
